keypad_hex_entry: RTL and testbench

Input-side counterpart of the 4-digit seven-segment display driver. The block scans a 4x4 matrix keypad column by column and debounces the key it finds. Each accepted key is shifted into a 16-bit four-hex-digit value `x`, which is exactly the word the display driver takes as its input. It sits between the board keypad pins and the display/command logic of the car controller.

---
 rtl/keypad_hex_entry.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// -----------------------------------------------------------------------------
// keypad_hex_entry
//
// Scans a 4x4 active-low matrix keypad one column at a time and debounces the
// key it finds. Each accepted key is shifted into a four-hex-digit entry word,
// which is the same format the seven-segment display driver takes.
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-high reset
//   row[3:0]     keypad rows, active-low, asynchronous to clk
//   col[3:0]     column drive, active-low, exactly one bit low
//   clear_entry  one-cycle request to zero x
//   x[15:0]      entered value, x[3:0] newest digit, x[15:12] oldest
//   key_code[3:0] code of the last accepted key ({row index, column index})
//   key_valid    one-clock pulse when a key is accepted
// -----------------------------------------------------------------------------
module keypad_hex_entry #(
    parameter int SCAN_DIV_BITS  = 18,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear_entry,
    output logic [15:0] x,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_TICKS);

    // Row synchronizer
    logic [3:0] r_row_meta;
    logic [3:0] r_row_s;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    // Scan prescaler: tick on the all-ones count, wrap is the natural overflow
    logic [SCAN_DIV_BITS-1:0] r_scan_cnt;
    logic                     w_tick;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_DIV_BITS'(1);
        end
    end

    assign w_tick = &r_scan_cnt;

    // Row decode: exactly one low row bit, and its index
    logic [3:0] w_row_low;
    logic       w_one_low;
    logic [1:0] w_row_idx;

    assign w_row_low = ~r_row_s;
    assign w_one_low = (w_row_low != 4'd0) &&
                       ((w_row_low & (w_row_low - 4'd1)) == 4'd0);

    always_comb begin
        w_row_idx = 2'd0;
        case (w_row_low)
            4'b0001: w_row_idx = 2'd0;
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // FSM and datapath registers
    state_t      r_state;
    logic [1:0]  r_c;
    logic [1:0]  r_r;
    logic [3:0]  r_pat;
    logic [3:0]  r_deb_cnt;
    logic [15:0] r_x;
    logic [3:0]  r_key_code;
    logic        r_key_valid;

    state_t      w_state_next;
    logic [1:0]  w_c_next;
    logic [1:0]  w_r_next;
    logic [3:0]  w_pat_next;
    logic [3:0]  w_deb_next;
    logic [3:0]  w_deb_inc;
    logic        w_accept;
    logic [3:0]  w_code;
    logic [15:0] w_x_next;
    logic [3:0]  w_key_code_next;

    assign w_deb_inc = r_deb_cnt + 4'd1;
    // Column is frozen from capture to acceptance, so the live column index
    // is the captured one.
    assign w_code    = {r_r, r_c};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_SCAN;
            r_c         <= 2'd0;
            r_r         <= 2'd0;
            r_pat       <= 4'hF;
            r_deb_cnt   <= 4'd0;
            r_x         <= 16'h0000;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_c         <= w_c_next;
            r_r         <= w_r_next;
            r_pat       <= w_pat_next;
            r_deb_cnt   <= w_deb_next;
            r_x         <= w_x_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_accept;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_c_next     = r_c;
        w_r_next     = r_r;
        w_pat_next   = r_pat;
        w_deb_next   = r_deb_cnt;
        w_accept     = 1'b0;

        // Ticks are the only FSM event; everything holds between them.
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_one_low) begin
                        w_r_next     = w_row_idx;
                        w_pat_next   = r_row_s;
                        w_deb_next   = 4'd1;
                        w_state_next = ST_DEBOUNCE;
                    end else begin
                        w_c_next = r_c + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_s == r_pat) begin
                        if (w_deb_inc == DEB_TARGET) begin
                            w_accept     = 1'b1;
                            w_deb_next   = 4'd0;
                            w_state_next = ST_HELD;
                        end else begin
                            w_deb_next = w_deb_inc;
                        end
                    end else begin
                        w_deb_next   = 4'd0;
                        w_c_next     = r_c + 2'd1;
                        w_state_next = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any low row restarts the release count: no auto-repeat,
                    // extra keys and re-bounce are ignored.
                    if (r_row_s == 4'hF) begin
                        if (w_deb_inc == DEB_TARGET) begin
                            w_deb_next   = 4'd0;
                            w_c_next     = r_c + 2'd1;
                            w_state_next = ST_SCAN;
                        end else begin
                            w_deb_next = w_deb_inc;
                        end
                    end else begin
                        w_deb_next = 4'd0;
                    end
                end
                default: begin
                    w_deb_next   = 4'd0;
                    w_state_next = ST_SCAN;
                end
            endcase
        end
    end

    // Clear has priority over a coincident accept for x only.
    always_comb begin
        w_x_next        = r_x;
        w_key_code_next = r_key_code;
        if (w_accept) begin
            w_key_code_next = w_code;
            w_x_next        = {r_x[11:0], w_code};
        end
        if (clear_entry) begin
            w_x_next = 16'h0000;
        end
    end

    assign col       = ~(4'b0001 << r_c);
    assign x         = r_x;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_hex_entry
//
// Directed bench for keypad_hex_entry with a 4-clock tick and 3-tick debounce.
// A keypad model pulls row r low while col[c] is low and key (r,c) is pressed.
// -----------------------------------------------------------------------------
module tb_keypad_hex_entry;

    localparam int SDB = 2;
    localparam int DT  = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        clear_entry = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] x;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] pressed = 16'h0000;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;
    int base;
    logic [3:0] col_prev;

    always #5 clk = ~clk;

    keypad_hex_entry #(
        .SCAN_DIV_BITS  (SDB),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .row         (row),
        .col         (col),
        .clear_entry (clear_entry),
        .x           (x),
        .key_code    (key_code),
        .key_valid   (key_valid)
    );

    // Keypad matrix model
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!key_valid && n < bound);
        chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (col == target && n < 64) begin step(1); n++; end
        while (col != target && n < 128) begin step(1); n++; end
        chk({tag, "_col"}, 32'(col), 32'(target));
    endtask

    task automatic enter_key(input logic [3:0] code);
        pressed = 16'(1) << code;
        wait_valid("enter", 80);
        chk("enter_code", 32'(key_code), 32'(code));
        $display("key %h accepted, x=%h", code, x);
        step(1);
        chk("enter_pulse_width", 32'(key_valid), 32'd0);
        step(16);
        pressed = 16'h0000;
        step(28);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_col", 32'(col), 32'h0000000E);
        chk("rst_x", 32'(x), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        clr = 1'b0;

        // Reset mid-operation while HELD with x=1234
        base = pulse_cnt;
        enter_key(4'h1);
        enter_key(4'h2);
        enter_key(4'h3);
        pressed = 16'(1) << 4;
        wait_valid("hold4", 80);
        chk("hold4_x", 32'(x), 32'h1234);
        step(5);
        chk("hold4_pulses", 32'(pulse_cnt - base), 32'd4);
        clr = 1'b1;
        #1;
        chk("clr_col", 32'(col), 32'h0000000E);
        chk("clr_x", 32'(x), 32'h0);
        chk("clr_valid", 32'(key_valid), 32'h0);
        chk("clr_code", 32'(key_code), 32'h0);
        pressed = 16'h0000;
        step(4);
        clr = 1'b0;
        step(3);
        chk("clr_col_clk3", 32'(col), 32'h0000000E);
        step(1);
        chk("clr_col_clk4", 32'(col), 32'h0000000D);

        // Five keys in sequence
        base = pulse_cnt;
        for (int k = 1; k <= 5; k++) enter_key(4'(k));
        chk("five_x", 32'(x), 32'h2345);
        chk("five_pulses", 32'(pulse_cnt - base), 32'd5);

        // Stand-alone clear
        clear_entry = 1'b1;
        step(1);
        clear_entry = 1'b0;
        chk("clear_x", 32'(x), 32'h0);

        // Single key (1,2) held 100 ticks
        base = pulse_cnt;
        pressed = 16'(1) << 6;
        wait_valid("key6", 80);
        chk("key6_code", 32'(key_code), 32'h6);
        chk("key6_x", 32'(x), 32'h0006);
        for (int t = 0; t < 100; t++) begin
            step(4);
            chk("key6_col_held", 32'(col), 32'h0000000B);
        end
        pressed = 16'h0000;
        step(40);
        chk("key6_pulses", 32'(pulse_cnt - base), 32'd1);

        // Press bounce: row low one tick only
        base = pulse_cnt;
        wait_col("bnc", 4'b1110);
        pressed = 16'h0001;
        step(4);
        chk("bnc_frozen", 32'(col), 32'h0000000E);
        pressed = 16'h0000;
        step(3);
        chk("bnc_still", 32'(col), 32'h0000000E);
        step(1);
        chk("bnc_advance", 32'(col), 32'h0000000D);
        step(20);
        chk("bnc_pulses", 32'(pulse_cnt - base), 32'd0);

        // Release bounce in HELD: high 2 ticks, low 1, high 3
        base = pulse_cnt;
        pressed = 16'(1) << 7;
        wait_valid("rb", 80);
        chk("rb_code", 32'(key_code), 32'h7);
        pressed = 16'h0000;
        step(8);
        pressed = 16'(1) << 7;
        step(4);
        pressed = 16'h0000;
        chk("rb_held_a", 32'(col), 32'h00000007);
        step(11);
        chk("rb_held_b", 32'(col), 32'h00000007);
        step(1);
        chk("rb_leave", 32'(col), 32'h0000000E);
        step(20);
        chk("rb_pulses", 32'(pulse_cnt - base), 32'd1);

        // Two rows low in one column
        base = pulse_cnt;
        pressed = (16'(1) << 1) | (16'(1) << 9);
        step(40);
        col_prev = col;
        step(4);
        chk("mr_scanning", 32'(col != col_prev), 32'd1);
        chk("mr_pulses", 32'(pulse_cnt - base), 32'd0);
        pressed = 16'(1) << 1;
        wait_valid("mr", 80);
        chk("mr_code", 32'(key_code), 32'h1);
        pressed = 16'h0000;
        step(32);

        // Clear coincides with accept of F
        clear_entry = 1'b1;
        step(1);
        clear_entry = 1'b0;
        enter_key(4'hA);
        enter_key(4'hB);
        enter_key(4'hC);
        enter_key(4'hD);
        chk("abcd_x", 32'(x), 32'hABCD);
        wait_col("cf", 4'b0111);
        pressed = 16'(1) << 15;
        step(11);
        clear_entry = 1'b1;
        step(1);
        clear_entry = 1'b0;
        chk("cf_x", 32'(x), 32'h0);
        chk("cf_valid", 32'(key_valid), 32'd1);
        chk("cf_code", 32'(key_code), 32'hF);
        pressed = 16'h0000;
        step(32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
